// File: rtl/ime_acc_tree_mc_if.sv
// ime_acc_tree_mc_if
// Bundles every signal of the multi-channel frame accumulator, apart from clk/rst,
// so the accumulator and its driver share one connection.
//   input stream  : in_valid/in_ready, in_data, in_ch, in_tuser, in_last, in_poison
//   flush request : flush_valid/flush_ready, flush_ch
//   configuration : cfg_tree_type, cfg_frame_len, cfg_sat_en, credit_sel
//   output stream : out_valid/out_ready, out_frame_acc, out_ch, out_tuser, out_count,
//                   out_last, out_poison, out_overflow
//   status        : credit_depth
// master = producer/consumer around the accumulator, slave = the accumulator itself.
interface ime_acc_tree_mc_if #(
   parameter int W_IN  = 32,
   parameter int W_ACC = 40,
   parameter int N_CH  = 4
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic                    in_valid;
   logic                    in_ready;
   logic signed [W_IN-1:0]  in_data;
   logic [CH_W-1:0]         in_ch;
   logic [7:0]              in_tuser;
   logic                    in_last;
   logic                    in_poison;

   logic                    flush_valid;
   logic                    flush_ready;
   logic [CH_W-1:0]         flush_ch;

   logic                    cfg_tree_type;
   logic [15:0]             cfg_frame_len;
   logic                    cfg_sat_en;
   logic [CH_W-1:0]         credit_sel;

   logic                    out_valid;
   logic                    out_ready;
   logic signed [W_ACC-1:0] out_frame_acc;
   logic [CH_W-1:0]         out_ch;
   logic [7:0]              out_tuser;
   logic [15:0]             out_count;
   logic                    out_last;
   logic                    out_poison;
   logic                    out_overflow;

   logic [15:0]             credit_depth;

   modport master (
      output in_valid, in_data, in_ch, in_tuser, in_last, in_poison,
      output flush_valid, flush_ch,
      output cfg_tree_type, cfg_frame_len, cfg_sat_en, credit_sel,
      output out_ready,
      input  in_ready, flush_ready,
      input  out_valid, out_frame_acc, out_ch, out_tuser, out_count,
      input  out_last, out_poison, out_overflow,
      input  credit_depth
   );

   modport slave (
      input  in_valid, in_data, in_ch, in_tuser, in_last, in_poison,
      input  flush_valid, flush_ch,
      input  cfg_tree_type, cfg_frame_len, cfg_sat_en, credit_sel,
      input  out_ready,
      output in_ready, flush_ready,
      output out_valid, out_frame_acc, out_ch, out_tuser, out_count,
      output out_last, out_poison, out_overflow,
      output credit_depth
   );
endinterface

// File: rtl/ime_acc_tree_mc.sv
// ime_acc_tree_mc
// N_CH independent signed frame accumulators fed by one sample stream (channel chosen
// per beat). A frame closes on in_last, on reaching cfg_frame_len samples (tree mode),
// or on a flush request; the closed frame is queued in an OUT_DEPTH-entry FIFO so the
// input side never waits on out_ready directly.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : ime_acc_tree_mc_if.slave carrying input stream, flush request,
//              configuration, output stream and credit_depth status
module ime_acc_tree_mc #(
   parameter int W_IN      = 32,
   parameter int W_ACC     = 40,
   parameter int N_CH      = 4,
   parameter int OUT_DEPTH = 4
) (
   input logic            clk,
   input logic            rst,
   ime_acc_tree_mc_if.slave bus
);
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CNT_W = $clog2(OUT_DEPTH + 1);

   localparam logic signed [W_ACC-1:0] ACC_MAX = {1'b0, {(W_ACC-1){1'b1}}};
   localparam logic signed [W_ACC-1:0] ACC_MIN = {1'b1, {(W_ACC-1){1'b0}}};

   typedef struct packed {
      logic signed [W_ACC-1:0] acc;
      logic [CH_W-1:0]         ch;
      logic [7:0]              tuser;
      logic [15:0]             count;
      logic                    last;
      logic                    poison;
      logic                    ovf;
   } entry_t;

   // Per-channel frame state
   logic signed [W_ACC-1:0] acc_r  [N_CH];
   logic [15:0]             cnt_r  [N_CH];
   logic                    poi_r  [N_CH];
   logic                    ovf_r  [N_CH];
   logic signed [W_ACC-1:0] acc_n  [N_CH];
   logic [15:0]             cnt_n  [N_CH];
   logic                    poi_n  [N_CH];
   logic                    ovf_n  [N_CH];

   // Output FIFO
   entry_t                  mem [OUT_DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [CNT_W-1:0]        fifo_cnt;
   entry_t                  head;

   logic                    not_full;
   logic                    in_fire;
   logic                    flush_fire;
   logic                    pop;
   logic                    push;
   entry_t                  push_e;

   logic signed [W_ACC-1:0] ext;
   logic signed [W_ACC-1:0] cur_acc;
   logic signed [W_ACC-1:0] raw_sum;
   logic signed [W_ACC-1:0] sum;
   logic [15:0]             cur_cnt;
   logic [15:0]             cnt_inc;
   logic [16:0]             cnt_plus;
   logic [15:0]             len_eff;
   logic                    add_ovf;
   logic                    sum_ovf;
   logic                    done;
   logic [15:0]             f_cnt;
   logic [15:0]             cr_cnt;
   logic [15:0]             credit_next;
   logic [15:0]             credit_q;

   // Handshakes: input beats take priority over flush so at most one push per cycle.
   assign not_full        = (fifo_cnt != CNT_W'(OUT_DEPTH));
   assign bus.in_ready    = not_full;
   assign bus.flush_ready = not_full & ~bus.in_valid;
   assign in_fire         = bus.in_valid & not_full;
   assign flush_fire      = bus.flush_valid & not_full & ~bus.in_valid;
   assign pop             = bus.out_valid & bus.out_ready;

   assign len_eff = (bus.cfg_frame_len == 16'd0) ? 16'd1 : bus.cfg_frame_len;

   // Sample arithmetic for the addressed channel. The first sample of a frame loads
   // rather than adds, so it can never overflow. Overflow is the classic signed test:
   // operands share a sign and the result sign differs.
   always_comb begin
      ext      = W_ACC'(bus.in_data);
      cur_acc  = acc_r[bus.in_ch];
      cur_cnt  = cnt_r[bus.in_ch];
      raw_sum  = cur_acc + ext;
      add_ovf  = (cur_acc[W_ACC-1] == ext[W_ACC-1]) && (raw_sum[W_ACC-1] != cur_acc[W_ACC-1]);
      cnt_plus = {1'b0, cur_cnt} + 17'd1;
      cnt_inc  = (cur_cnt == 16'hFFFF) ? cur_cnt : cur_cnt + 16'd1;
      done     = bus.in_last | (bus.cfg_tree_type & (cnt_plus >= {1'b0, len_eff}));
      if (cur_cnt == 16'd0) begin
         sum     = ext;
         sum_ovf = 1'b0;
      end else begin
         sum_ovf = add_ovf;
         if (add_ovf && bus.cfg_sat_en) begin
            sum = ext[W_ACC-1] ? ACC_MIN : ACC_MAX;
         end else begin
            sum = raw_sum;
         end
      end
   end

   // Next channel state and FIFO push: a sample either accumulates or closes its frame;
   // a flush closes a non-empty partial frame and is silently consumed otherwise.
   always_comb begin
      acc_n  = acc_r;
      cnt_n  = cnt_r;
      poi_n  = poi_r;
      ovf_n  = ovf_r;
      push   = 1'b0;
      push_e = '0;
      f_cnt  = cnt_r[bus.flush_ch];
      if (in_fire) begin
         if (done) begin
            push          = 1'b1;
            push_e.acc    = sum;
            push_e.ch     = bus.in_ch;
            push_e.tuser  = bus.in_tuser;
            push_e.count  = cnt_inc;
            push_e.last   = 1'b1;
            push_e.poison = poi_r[bus.in_ch] | bus.in_poison;
            push_e.ovf    = ovf_r[bus.in_ch] | sum_ovf;
            acc_n[bus.in_ch] = '0;
            cnt_n[bus.in_ch] = '0;
            poi_n[bus.in_ch] = 1'b0;
            ovf_n[bus.in_ch] = 1'b0;
         end else begin
            acc_n[bus.in_ch] = sum;
            cnt_n[bus.in_ch] = cnt_inc;
            poi_n[bus.in_ch] = poi_r[bus.in_ch] | bus.in_poison;
            ovf_n[bus.in_ch] = ovf_r[bus.in_ch] | sum_ovf;
         end
      end else if (flush_fire && (f_cnt != 16'd0)) begin
         push          = 1'b1;
         push_e.acc    = acc_r[bus.flush_ch];
         push_e.ch     = bus.flush_ch;
         push_e.tuser  = 8'd0;
         push_e.count  = f_cnt;
         push_e.last   = 1'b0;
         push_e.poison = poi_r[bus.flush_ch];
         push_e.ovf    = ovf_r[bus.flush_ch];
         acc_n[bus.flush_ch] = '0;
         cnt_n[bus.flush_ch] = '0;
         poi_n[bus.flush_ch] = 1'b0;
         ovf_n[bus.flush_ch] = 1'b0;
      end
   end

   // Credit is taken from the post-update count so it matches the state after this edge.
   always_comb begin
      cr_cnt      = cnt_n[bus.credit_sel];
      credit_next = (len_eff > cr_cnt) ? (len_eff - cr_cnt) : 16'd0;
   end

   // State registers: channel state, FIFO pointers/occupancy and the credit report.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r    <= '{default: '0};
         cnt_r    <= '{default: '0};
         poi_r    <= '{default: 1'b0};
         ovf_r    <= '{default: 1'b0};
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         credit_q <= '0;
      end else begin
         acc_r    <= acc_n;
         cnt_r    <= cnt_n;
         poi_r    <= poi_n;
         ovf_r    <= ovf_n;
         credit_q <= credit_next;
         if (push) begin
            wr_ptr <= (wr_ptr == PTR_W'(OUT_DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_W'(OUT_DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // FIFO storage needs no reset: the head is only exposed while occupancy is non-zero.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_e;
      end
   end

   assign head              = mem[rd_ptr];
   assign bus.out_valid     = (fifo_cnt != '0);
   assign bus.out_frame_acc = bus.out_valid ? head.acc    : '0;
   assign bus.out_ch        = bus.out_valid ? head.ch     : '0;
   assign bus.out_tuser     = bus.out_valid ? head.tuser  : '0;
   assign bus.out_count     = bus.out_valid ? head.count  : '0;
   assign bus.out_last      = bus.out_valid ? head.last   : 1'b0;
   assign bus.out_poison    = bus.out_valid ? head.poison : 1'b0;
   assign bus.out_overflow  = bus.out_valid ? head.ovf    : 1'b0;
   assign bus.credit_depth  = credit_q;

endmodule

// File: tb/tb_ime_acc_tree_mc.sv
// tb_ime_acc_tree_mc
// Directed self-checking bench for ime_acc_tree_mc: single and interleaved frames,
// saturating/wrapping overflow, FIFO back-pressure, poison + flush, credit and reset.
module tb_ime_acc_tree_mc;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   ime_acc_tree_mc_if #(.W_IN(32), .W_ACC(40), .N_CH(4)) bus ();

   ime_acc_tree_mc #(.W_IN(32), .W_ACC(40), .N_CH(4), .OUT_DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input longint observed, input longint expected);
      n_cmp++;
      assert (observed === expected) else begin
         n_err++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic apply_sample(input logic [1:0] ch, input logic signed [31:0] data,
                               input logic last, input logic poison, input logic [7:0] tuser);
      bus.in_valid  = 1'b1;
      bus.in_ch     = ch;
      bus.in_data   = data;
      bus.in_last   = last;
      bus.in_poison = poison;
      bus.in_tuser  = tuser;
      tick();
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.in_poison = 1'b0;
      bus.in_tuser  = 8'd0;
   endtask

   task automatic check_head(input string tag, input longint acc, input longint ch,
                             input longint count, input longint last, input longint poison,
                             input longint ovf, input longint tuser);
      check_output({tag, ".valid"},  longint'(bus.out_valid), 1);
      check_output({tag, ".acc"},    longint'(bus.out_frame_acc), acc);
      check_output({tag, ".ch"},     longint'(bus.out_ch), ch);
      check_output({tag, ".count"},  longint'(bus.out_count), count);
      check_output({tag, ".last"},   longint'(bus.out_last), last);
      check_output({tag, ".poison"}, longint'(bus.out_poison), poison);
      check_output({tag, ".ovf"},    longint'(bus.out_overflow), ovf);
      check_output({tag, ".tuser"},  longint'(bus.out_tuser), tuser);
   endtask

   task automatic pop_one();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst               = 1'b1;
      bus.in_valid      = 1'b0;
      bus.in_data       = '0;
      bus.in_ch         = '0;
      bus.in_tuser      = '0;
      bus.in_last       = 1'b0;
      bus.in_poison     = 1'b0;
      bus.flush_valid   = 1'b0;
      bus.flush_ch      = '0;
      bus.cfg_tree_type = 1'b1;
      bus.cfg_frame_len = 16'd4;
      bus.cfg_sat_en    = 1'b0;
      bus.credit_sel    = '0;
      bus.out_ready     = 1'b0;

      // Reset state
      tick();
      tick();
      check_output("rst.out_valid", longint'(bus.out_valid), 0);
      check_output("rst.credit", longint'(bus.credit_depth), 0);
      check_output("rst.in_ready", longint'(bus.in_ready), 1);
      check_output("rst.out_acc", longint'(bus.out_frame_acc), 0);
      rst = 1'b0;
      tick();
      $display("[TB] reset released");

      // Length-closed frame on ch0: 1+2+3+4
      apply_sample(2'd0, 32'sd1, 1'b0, 1'b0, 8'h00);
      apply_sample(2'd0, 32'sd2, 1'b0, 1'b0, 8'h00);
      apply_sample(2'd0, 32'sd3, 1'b0, 1'b0, 8'h00);
      check_output("len.not_yet", longint'(bus.out_valid), 0);
      apply_sample(2'd0, 32'sd4, 1'b0, 1'b0, 8'hA5);
      check_head("len", 10, 0, 4, 1, 0, 0, 8'hA5);
      pop_one();
      check_output("len.drained", longint'(bus.out_valid), 0);

      // Interleaved channels, closed by in_last; FIFO keeps push order
      bus.cfg_tree_type = 1'b0;
      apply_sample(2'd1, 32'sd5, 1'b0, 1'b0, 8'h00);
      apply_sample(2'd2, 32'sd100, 1'b1, 1'b0, 8'h22);
      apply_sample(2'd1, -32'sd7, 1'b1, 1'b0, 8'h11);
      check_head("ilv.ch2", 100, 2, 1, 1, 0, 0, 8'h22);
      pop_one();
      check_head("ilv.ch1", -2, 1, 2, 1, 0, 0, 8'h11);
      pop_one();

      // Saturating overflow: 257 x 0x7FFFFFFF exceeds 2^39-1 on the final sample
      bus.cfg_sat_en = 1'b1;
      for (int i = 0; i < 256; i++) apply_sample(2'd3, 32'sh7FFFFFFF, 1'b0, 1'b0, 8'h00);
      apply_sample(2'd3, 32'sh7FFFFFFF, 1'b1, 1'b0, 8'h33);
      check_head("sat", 64'sd549755813887, 3, 257, 1, 0, 1, 8'h33);
      pop_one();

      // Same stimulus wrapping: 257*(2^31-1) - 2^40
      bus.cfg_sat_en = 1'b0;
      for (int i = 0; i < 256; i++) apply_sample(2'd3, 32'sh7FFFFFFF, 1'b0, 1'b0, 8'h00);
      apply_sample(2'd3, 32'sh7FFFFFFF, 1'b1, 1'b0, 8'h33);
      check_head("wrap", -64'sd547608330497, 3, 257, 1, 0, 1, 8'h33);
      pop_one();

      // Back-pressure: four queued frames fill the FIFO
      apply_sample(2'd0, 32'sd11, 1'b1, 1'b0, 8'h00);
      apply_sample(2'd1, 32'sd12, 1'b1, 1'b0, 8'h00);
      apply_sample(2'd2, 32'sd13, 1'b1, 1'b0, 8'h00);
      check_output("full.ready3", longint'(bus.in_ready), 1);
      apply_sample(2'd3, 32'sd14, 1'b1, 1'b0, 8'h00);
      check_output("full.ready4", longint'(bus.in_ready), 0);
      check_output("full.flush_ready", longint'(bus.flush_ready), 0);
      check_output("full.head", longint'(bus.out_frame_acc), 11);
      pop_one();
      check_output("full.ready_after_pop", longint'(bus.in_ready), 1);
      check_head("full.e2", 13 - 1, 1, 1, 1, 0, 0, 0);
      pop_one();
      check_output("full.e3", longint'(bus.out_frame_acc), 13);
      pop_one();
      check_output("full.e4", longint'(bus.out_frame_acc), 14);
      pop_one();
      check_output("full.empty", longint'(bus.out_valid), 0);

      // Poison + flush on ch0, then flush of an empty channel
      apply_sample(2'd0, 32'sd7, 1'b0, 1'b0, 8'h00);
      apply_sample(2'd0, 32'sd8, 1'b0, 1'b1, 8'h00);
      apply_sample(2'd0, 32'sd9, 1'b0, 1'b0, 8'h00);
      bus.in_valid = 1'b1;
      #1;
      check_output("flush.blocked_by_input", longint'(bus.flush_ready), 0);
      bus.in_valid    = 1'b0;
      bus.flush_valid = 1'b1;
      bus.flush_ch    = 2'd0;
      #1;
      check_output("flush.ready", longint'(bus.flush_ready), 1);
      tick();
      bus.flush_valid = 1'b0;
      check_head("flush", 24, 0, 3, 0, 1, 0, 0);
      pop_one();
      bus.flush_valid = 1'b1;
      bus.flush_ch    = 2'd1;
      tick();
      bus.flush_valid = 1'b0;
      check_output("flush_empty.no_out", longint'(bus.out_valid), 0);
      tick();
      check_output("flush_empty.still_none", longint'(bus.out_valid), 0);

      // Credit report and reset mid-frame
      bus.cfg_tree_type = 1'b1;
      bus.cfg_frame_len = 16'd8;
      bus.credit_sel    = 2'd2;
      apply_sample(2'd2, 32'sd1, 1'b0, 1'b0, 8'h00);
      check_output("credit.one", longint'(bus.credit_depth), 7);
      apply_sample(2'd2, 32'sd1, 1'b0, 1'b0, 8'h00);
      apply_sample(2'd2, 32'sd1, 1'b0, 1'b0, 8'h00);
      check_output("credit.three", longint'(bus.credit_depth), 5);
      apply_sample(2'd0, 32'sd1, 1'b1, 1'b0, 8'h00);
      check_output("credit.other_ch", longint'(bus.credit_depth), 5);
      rst = 1'b1;
      tick();
      check_output("midrst.credit", longint'(bus.credit_depth), 0);
      check_output("midrst.out_valid", longint'(bus.out_valid), 0);
      rst = 1'b0;
      tick();
      check_output("postrst.credit", longint'(bus.credit_depth), 8);
      apply_sample(2'd2, 32'sd1, 1'b0, 1'b0, 8'h00);
      check_output("postrst.partial_discarded", longint'(bus.credit_depth), 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
